instruction_memory_responder: RTL and testbench
===============================================

INSTRUCTION_MEMORY_RESPONDER -- requirements
Module: instruction_memory_responder

Interface
REQ-001 The block SHALL have parameter DEPTH_WORDS, default 1024, which sets the number of 32-bit instruction words in the backing store (power of two).
REQ-002 The block SHALL have parameter LATENCY, default 2, which sets the request-to-response delay in cycles (legal range 1..4).
REQ-003 The block SHALL have parameter MAX_OUTSTANDING, default 2, which sets the maximum number of accepted-but-unconsumed requests (legal range 1..4).
REQ-004 i_Clock  input  1  the single clock; all state SHALL update on its rising edge.
REQ-005 i_Reset  input  1  reset, synchronous and active-high.
REQ-006 i_ReqValid  input  1  a fetch request is present.
REQ-007 o_ReqReady  output  1  the block can accept a request this cycle.
REQ-008 i_ReqAddress  input  32  byte address of the instruction to fetch.
REQ-009 o_RespValid  output  1  a response is present.
REQ-010 i_RespReady  input  1  the consumer accepts the response this cycle.
REQ-011 o_RespData  output  32  the instruction word.
REQ-012 o_RespAddress  output  32  the request address that this response answers.
REQ-013 o_RespError  output  1  the request was misaligned or out of range.
REQ-014 i_WriteEnable  input  1  program-load write strobe.
REQ-015 i_WriteAddress  input  32  byte address for the program-load write.
REQ-016 i_WriteData  input  32  program-load word.

Function
REQ-017 A request SHALL be accepted at a rising edge where i_ReqValid=1, o_ReqReady=1 and i_Reset=0.
REQ-018 o_ReqReady SHALL be 1 exactly when the registered outstanding count is below MAX_OUTSTANDING, and SHALL NOT depend combinationally on i_RespReady or i_ReqValid.
REQ-019 The outstanding count SHALL increment on each accept and decrement on each consume (o_RespValid and i_RespReady both 1 at an edge); if an accept and a consume occur at the same edge, the count SHALL stay unchanged.
REQ-020 The backing store SHALL be read at the accepting edge, read-before-write: a write at that same edge to the same word SHALL NOT be visible in that response.
REQ-021 A request accepted at edge E SHALL make its response eligible at edge E+LATENCY; o_RespValid SHALL go to 1 in the cycle following that edge if that response is at the head of the queue.
REQ-022 Responses SHALL be returned strictly in acceptance order, and none SHALL be dropped or duplicated.
REQ-023 Completed responses SHALL wait in an internal buffer sized to MAX_OUTSTANDING, so that a request is never lost while i_RespReady=0.
REQ-024 While o_RespValid=1 and i_RespReady=0, o_RespData, o_RespAddress and o_RespError SHALL be held stable.
REQ-025 When o_RespValid=0, o_RespData, o_RespAddress and o_RespError SHALL be 0.
REQ-026 If i_ReqAddress[1:0] is not 0, the response SHALL carry o_RespError=1 and o_RespData=0.
REQ-027 If i_ReqAddress[31:2] is at or above DEPTH_WORDS, the response SHALL carry o_RespError=1 and o_RespData=0.
REQ-028 Otherwise, the response SHALL carry o_RespError=0 and o_RespData equal to the store word at index i_ReqAddress[31:2].
REQ-029 When i_WriteEnable=1 and i_Reset=0, the store word at i_WriteAddress[31:2] SHALL be written at the edge; the write SHALL be ignored if that index is out of range, and i_WriteAddress[1:0] SHALL be ignored.
REQ-030 Back-to-back throughput SHALL be one response per cycle when i_RespReady=1 continuously and MAX_OUTSTANDING is at least LATENCY+1.
REQ-031 With MAX_OUTSTANDING at or below LATENCY, o_ReqReady SHALL deassert when the count is full and reassert in the cycle after a consume.

Reset
REQ-032 While i_Reset=1, o_ReqReady, o_RespValid, o_RespData, o_RespAddress and o_RespError SHALL be 0.
REQ-033 A reset edge SHALL clear the outstanding count, all in-flight requests and all buffered responses, including a reset asserted mid-operation.
REQ-034 Store contents SHALL be retained across reset, and writes SHALL be ignored during reset.
REQ-035 In the first cycle after i_Reset deasserts, o_ReqReady SHALL be 1.

Verification
REQ-036 Load scenario: write 0x00500093 to 0x0 and 0x00A00113 to 0x4, then request 0x0 with LATENCY=2 and i_RespReady=1 -> o_RespValid=1 two cycles after acceptance, with o_RespData=0x00500093, o_RespAddress=0x0 and o_RespError=0.
REQ-037 Backpressure scenario: request 0x0 then 0x4 with i_RespReady=0 -> o_ReqReady=0 after two accepts, 0x00500093 held stable; then raise i_RespReady -> 0x00500093 is returned followed by 0x00A00113, and o_ReqReady=1 one cycle after the first consume.
REQ-038 Error scenario: request 0x2 -> o_RespError=1 and o_RespData=0; request 0x1000 (index 1024) -> o_RespError=1 and o_RespData=0.
REQ-039 Simultaneous scenario: at full count, consume and accept at the same edge -> count stays at 2 and ordering is preserved; a write of 0xDEADBEEF to 0x0 at the accept edge of 0x0 -> the response returns the old word.
REQ-040 Reset scenario: assert i_Reset with 2 outstanding requests -> after release there is no o_RespValid and o_ReqReady=1, and a later request to 0x4 returns 0x00A00113 (store retained).

Source files
------------

// File: rtl/instruction_memory_responder.sv
// Fixed-latency instruction store with a valid/ready request port and an in-order response buffer.
// Also provides a program-load write port; store contents survive reset.
module instruction_memory_responder #(
  parameter int unsigned DEPTH_WORDS     = 1024,
  parameter int unsigned LATENCY         = 2,
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic        i_Clock,
  input  logic        i_Reset,
  input  logic        i_ReqValid,
  output logic        o_ReqReady,
  input  logic [31:0] i_ReqAddress,
  output logic        o_RespValid,
  input  logic        i_RespReady,
  output logic [31:0] o_RespData,
  output logic [31:0] o_RespAddress,
  output logic        o_RespError,
  input  logic        i_WriteEnable,
  input  logic [31:0] i_WriteAddress,
  input  logic [31:0] i_WriteData
);

  localparam int unsigned IdxW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int unsigned CntW = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned PtrW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam logic [CntW-1:0] MaxCnt = CntW'(MAX_OUTSTANDING);

  typedef struct packed {
    logic [31:0] data;
    logic [31:0] addr;
    logic        err;
  } resp_t;

  logic [31:0]     mem_q [DEPTH_WORDS];
  logic [CntW-1:0] cnt_q, cnt_d;
  resp_t           pipe_q [LATENCY];
  logic [LATENCY-1:0] pipe_vld_q;
  resp_t           fifo_q [MAX_OUTSTANDING];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] fifo_cnt_q, fifo_cnt_d;

  logic        accept, consume, push;
  logic [31:0] req_word, wr_word;
  logic        req_in_range, wr_in_range;
  resp_t       req_resp, head;
  logic        unused_wr_lsbs;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(MAX_OUTSTANDING - 1)) ? '0 : p + 1'b1;
  endfunction

  assign req_word       = {2'b00, i_ReqAddress[31:2]};
  assign wr_word        = {2'b00, i_WriteAddress[31:2]};
  assign req_in_range   = req_word < DEPTH_WORDS;
  assign wr_in_range    = wr_word < DEPTH_WORDS;
  assign unused_wr_lsbs = ^i_WriteAddress[1:0];

  // Store read is combinational and captured at the accepting edge, so a same-edge
  // write (non-blocking) is never visible in this response.
  always_comb begin
    req_resp.addr = i_ReqAddress;
    req_resp.err  = (i_ReqAddress[1:0] != 2'b00) || !req_in_range;
    req_resp.data = '0;
    if (!req_resp.err) req_resp.data = mem_q[req_word[IdxW-1:0]];
  end

  assign o_ReqReady  = !i_Reset && (cnt_q < MaxCnt);
  assign accept      = i_ReqValid && o_ReqReady;
  assign o_RespValid = !i_Reset && (fifo_cnt_q != '0);
  assign consume     = o_RespValid && i_RespReady;
  assign push        = pipe_vld_q[LATENCY-1];
  assign head        = fifo_q[rd_ptr_q];

  always_comb begin
    o_RespData    = '0;
    o_RespAddress = '0;
    o_RespError   = 1'b0;
    if (o_RespValid) begin
      o_RespData    = head.data;
      o_RespAddress = head.addr;
      o_RespError   = head.err;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (accept && !consume) cnt_d = cnt_q + 1'b1;
    else if (!accept && consume) cnt_d = cnt_q - 1'b1;
  end

  // The outstanding count bounds in-flight plus buffered entries, so the buffer cannot overflow.
  always_comb begin
    fifo_cnt_d = fifo_cnt_q;
    if (push && !consume) fifo_cnt_d = fifo_cnt_q + 1'b1;
    else if (!push && consume) fifo_cnt_d = fifo_cnt_q - 1'b1;
    wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = consume ? ptr_inc(rd_ptr_q) : rd_ptr_q;
  end

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      cnt_q      <= '0;
      fifo_cnt_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      pipe_vld_q <= '0;
    end else begin
      cnt_q         <= cnt_d;
      fifo_cnt_q    <= fifo_cnt_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      pipe_vld_q[0] <= accept;
      for (int unsigned k = 1; k < LATENCY; k++) begin
        pipe_vld_q[k] <= pipe_vld_q[k-1];
      end
    end
  end

  always_ff @(posedge i_Clock) begin
    pipe_q[0] <= req_resp;
    for (int unsigned k = 1; k < LATENCY; k++) begin
      pipe_q[k] <= pipe_q[k-1];
    end
    if (push && !i_Reset) fifo_q[wr_ptr_q] <= pipe_q[LATENCY-1];
  end

  always_ff @(posedge i_Clock) begin
    if (!i_Reset && i_WriteEnable && wr_in_range) begin
      mem_q[wr_word[IdxW-1:0]] <= i_WriteData;
    end
  end

endmodule

// File: tb/tb_instruction_memory_responder.sv
// Scoreboard bench: the driver predicts each accepted response from a reference store,
// a negedge monitor checks every cycle of the response port against the queue head.
module tb_instruction_memory_responder;

  localparam int unsigned Depth = 1024;
  localparam int unsigned Lat   = 2;
  localparam int unsigned MaxO  = 2;

  logic        clk = 1'b0;
  logic        i_Reset = 1'b1;
  logic        i_ReqValid = 1'b0;
  logic        o_ReqReady;
  logic [31:0] i_ReqAddress = '0;
  logic        o_RespValid;
  logic        i_RespReady = 1'b0;
  logic [31:0] o_RespData;
  logic [31:0] o_RespAddress;
  logic        o_RespError;
  logic        i_WriteEnable = 1'b0;
  logic [31:0] i_WriteAddress = '0;
  logic [31:0] i_WriteData = '0;

  always #5 clk = ~clk;

  instruction_memory_responder #(
    .DEPTH_WORDS    (Depth),
    .LATENCY        (Lat),
    .MAX_OUTSTANDING(MaxO)
  ) dut (
    .i_Clock       (clk),
    .i_Reset       (i_Reset),
    .i_ReqValid    (i_ReqValid),
    .o_ReqReady    (o_ReqReady),
    .i_ReqAddress  (i_ReqAddress),
    .o_RespValid   (o_RespValid),
    .i_RespReady   (i_RespReady),
    .o_RespData    (o_RespData),
    .o_RespAddress (o_RespAddress),
    .o_RespError   (o_RespError),
    .i_WriteEnable (i_WriteEnable),
    .i_WriteAddress(i_WriteAddress),
    .i_WriteData   (i_WriteData)
  );

  typedef struct {
    logic [31:0] data;
    logic [31:0] addr;
    logic        err;
    int          elig;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] ref_mem [Depth];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock cycle: drive inputs, check ready, predict the accept and apply the model write.
  task automatic step(input logic v, input logic [31:0] a, input logic rr, input logic we,
                      input logic [31:0] wa, input logic [31:0] wd, input logic rst);
    exp_t        e;
    logic        exp_rdy;
    logic [31:0] ridx, widx;
    @(posedge clk);
    #1;
    i_Reset        = rst;
    i_ReqValid     = v;
    i_ReqAddress   = a;
    i_RespReady    = rr;
    i_WriteEnable  = we;
    i_WriteAddress = wa;
    i_WriteData    = wd;
    #2;
    exp_rdy = !rst && (sb.size() < MaxO);
    chk("req_ready", 32'(o_ReqReady), 32'(exp_rdy));
    if (rst) begin
      sb.delete();
    end else begin
      if (v && o_ReqReady) begin
        ridx   = a >> 2;
        e.addr = a;
        e.err  = (a[1:0] != 2'b00) || (ridx >= Depth);
        e.data = e.err ? 32'h0 : ref_mem[ridx[9:0]];
        e.elig = cyc + 1 + Lat;
        sb.push_back(e);
      end
      widx = wa >> 2;
      if (we && widx < Depth) ref_mem[widx[9:0]] = wd;
    end
  endtask

  task automatic idle(input logic rr, input int n);
    for (int i = 0; i < n; i++) step(1'b0, 32'h0, rr, 1'b0, 32'h0, 32'h0, 1'b0);
  endtask

  task automatic req(input logic [31:0] a, input logic rr);
    step(1'b1, a, rr, 1'b0, 32'h0, 32'h0, 1'b0);
  endtask

  always @(negedge clk) begin : monitor
    logic exp_v;
    exp_v = !i_Reset && (sb.size() > 0) && (sb[0].elig <= cyc);
    chk("resp_valid", 32'(o_RespValid), 32'(exp_v));
    if (o_RespValid && sb.size() > 0) begin
      chk("resp_data", o_RespData, sb[0].data);
      chk("resp_addr", o_RespAddress, sb[0].addr);
      chk("resp_err", 32'(o_RespError), 32'(sb[0].err));
      if (i_RespReady) void'(sb.pop_front());
    end else if (!o_RespValid) begin
      chk("idle_data", o_RespData, 32'h0);
      chk("idle_addr", o_RespAddress, 32'h0);
      chk("idle_err", 32'(o_RespError), 32'h0);
    end
  end

  initial begin
    logic [31:0] a, wa;
    logic        v, rr, we, rst;
    for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);

    // Program load: first two words fixed, the rest of a 64-word window random.
    for (int i = 0; i < 64; i++) begin
      a = (i == 0) ? 32'h0050_0093 : (i == 1) ? 32'h00A0_0113 : $urandom;
      step(1'b0, 32'h0, 1'b1, 1'b1, 32'(i) << 2, a, 1'b0);
    end

    // Single fetch with consumer always ready.
    req(32'h0, 1'b1);
    idle(1'b1, 4);

    // Backpressure: two accepts fill the count, then release.
    req(32'h0, 1'b0);
    req(32'h4, 1'b0);
    idle(1'b0, 4);
    idle(1'b1, 4);

    // Misaligned and out-of-range fetches.
    req(32'h2, 1'b1);
    req(32'h1000, 1'b1);
    idle(1'b1, 4);

    // Accept and consume at the same edge, with a same-word write at the accept edge.
    req(32'h0, 1'b0);
    req(32'h4, 1'b0);
    idle(1'b0, 3);
    idle(1'b1, 1);
    step(1'b1, 32'h0, 1'b1, 1'b1, 32'h0, 32'hDEAD_BEEF, 1'b0);
    req(32'h4, 1'b1);
    idle(1'b1, 4);

    // Reset with two requests outstanding; store must survive.
    req(32'h0, 1'b0);
    req(32'h4, 1'b0);
    idle(1'b0, 1);
    step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
    step(1'b0, 32'h0, 1'b0, 1'b1, 32'h4, 32'h1111_1111, 1'b1);
    idle(1'b1, 2);
    req(32'h4, 1'b1);
    idle(1'b1, 4);

    // Random traffic.
    for (int n = 0; n < 3000; n++) begin
      v  = ($urandom_range(0, 99) < 60);
      rr = ($urandom_range(0, 3) != 0);
      we = ($urandom_range(0, 3) == 0);
      rst = ($urandom_range(0, 299) == 0);
      case ($urandom_range(0, 9))
        7:       a = (32'($urandom_range(0, 63)) << 2) | 32'($urandom_range(1, 3));
        8:       a = ($urandom | 32'h1000) & 32'hFFFF_FFFC;
        9:       a = $urandom | 32'h1001;
        default: a = 32'($urandom_range(0, 63)) << 2;
      endcase
      wa = ($urandom_range(0, 7) == 0) ? ($urandom | 32'h1000)
                                       : ((32'($urandom_range(0, 63)) << 2) | ($urandom & 32'h3));
      step(v, a, rr, we, wa, $urandom, rst);
    end

    idle(1'b1, 10);
    chk("drained", 32'(sb.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
